npu_bus_master: RTL

NPU_BUS_MASTER -- requirements
Module: npu_bus_master

---
 rtl/npu_bus_pkg.sv | 47 ++++
 rtl/npu_bus_master.sv | 129 ++++++++++++
 2 files changed

// File: rtl/npu_bus_pkg.sv
// Shared types for the NPU register-bus master: command opcodes, target selects, FSM states.
package npu_bus_pkg;

    localparam int unsigned SEL_W = 3;

    typedef enum logic [2:0] {
        POLL_VALID = 3'd0,
        WR_IMG     = 3'd1,
        WR_W       = 3'd2,
        WR_FCN     = 3'd3,
        WR_CTRL    = 3'd4,
        RD_DONE    = 3'd5,
        RD_RESULT  = 3'd6,
        RD_VALID   = 3'd7
    } op_e;

    localparam logic [SEL_W-1:0] SEL_IMG    = 3'd1;
    localparam logic [SEL_W-1:0] SEL_W_REG  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_FCN    = 3'd3;
    localparam logic [SEL_W-1:0] SEL_CTRL   = 3'd4;
    localparam logic [SEL_W-1:0] SEL_DONE   = 3'd5;
    localparam logic [SEL_W-1:0] SEL_RESULT = 3'd6;
    localparam logic [SEL_W-1:0] SEL_VALID  = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        GAP     = 3'd2,
        RD      = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

    function automatic logic is_write(input op_e op);
        return (op == WR_IMG) || (op == WR_W) || (op == WR_FCN) || (op == WR_CTRL);
    endfunction

    function automatic logic is_read(input op_e op);
        return (op == RD_DONE) || (op == RD_RESULT) || (op == RD_VALID) || (op == POLL_VALID);
    endfunction

    // Polling always targets the valid register; every other op encodes its own select.
    function automatic logic [SEL_W-1:0] sel_of(input op_e op);
        return (op == POLL_VALID) ? SEL_VALID : SEL_W'(op);
    endfunction

endpackage

// File: rtl/npu_bus_master.sv
// Command-to-NPU-register-bus master: single-cycle writes, two-cycle reads, optional valid polling.
// Define NPU_BUS_TIMEOUT_EN to bound POLL_VALID at POLL_MAX unsuccessful reads (flagged by rsp_err).
module npu_bus_master
    import npu_bus_pkg::*;
#(
    parameter int unsigned POLL_MAX = 255,
    parameter int unsigned SEL_LSB  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  op_e         req_op,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        ena,
    output logic        wea,
    output logic [15:0] addra,
    output logic [31:0] dina,
    input  logic [31:0] douta
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    state_e              state, state_d;
    op_e                 op_q, op_d;
    logic [CNT_W-1:0]    poll_cnt, poll_cnt_d;
    logic [SEL_W-1:0]    sel_d;
    logic                ena_d, wea_d, ready_d, rsp_valid_d, rsp_err_d;
    logic [ADDR_W-1:0]   addra_d;
    logic [DATA_W-1:0]   dina_d, rsp_data_d;
    logic                poll_timeout;

`ifdef NPU_BUS_TIMEOUT_EN
    assign poll_timeout = (poll_cnt == CNT_W'(POLL_MAX - 1));
`else
    assign poll_timeout = 1'b0;
`endif

    // Next state plus next value of every registered output, derived from the next state.
    always_comb begin
        state_d    = state;
        op_d       = op_q;
        poll_cnt_d = poll_cnt;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    poll_cnt_d = '0;
                    rsp_err_d  = 1'b0;
                    if (is_write(req_op)) begin
                        state_d = WR;
                    end else if (is_read(req_op)) begin
                        state_d = RD;
                    end
                end
            end
            WR:      state_d = (op_q == WR_CTRL) ? GAP : IDLE;
            GAP:     state_d = IDLE;
            RD:      state_d = RD_DATA;
            RD_DATA: begin
                rsp_data_d = douta;
                if (op_q != POLL_VALID || douta[0]) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b0;
                end else if (poll_timeout) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b1;
                end else begin
                    state_d    = RD;
                    poll_cnt_d = (poll_cnt == CNT_W'(POLL_MAX)) ? poll_cnt : poll_cnt + CNT_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sel_d       = sel_of(op_d);
        ena_d       = (state_d == WR) || (state_d == RD);
        wea_d       = (state_d == WR);
        addra_d     = ena_d ? (ADDR_W'(sel_d) << SEL_LSB) : '0;
        // WR is only ever entered straight from IDLE, so req_data is the accepted payload.
        dina_d      = wea_d ? req_data : '0;
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= POLL_VALID;
            poll_cnt  <= '0;
            ena       <= 1'b0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            poll_cnt  <= poll_cnt_d;
            ena       <= ena_d;
            wea       <= wea_d;
            addra     <= addra_d;
            dina      <= dina_d;
            req_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule
